// File: rtl/dmem_pkg.sv
// Shared constants and address helper for the core's data memory.
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_ADDR_WIDTH = 32;
  localparam int DMEM_DEPTH      = 1024;
  localparam int IDX_WIDTH       = $clog2(DMEM_DEPTH);

  // Byte address to word index; low two bits and bits above the index drop out.
  function automatic logic [IDX_WIDTH-1:0] addr_to_index(
    input logic [DMEM_ADDR_WIDTH-1:0] addr
  );
    return IDX_WIDTH'(addr >> 2);
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// DEPTH x DATA_WIDTH register array: sync write, async read, sync clear.
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int IW         = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  wrEn,
  input  logic [IW-1:0]         wrIdx,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic [IW-1:0]         rdIdx,
  output logic [DATA_WIDTH-1:0] rdData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrIdx] <= wrData;
    end
  end

  assign rdData = mem[rdIdx];

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory on the core's load/store bus.
// Optional access counters under DMEM_STATS_EN.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DEPTH      = DMEM_DEPTH
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  MemReadEn,
  input  logic                  MemWriteEn,
  input  logic [ADDR_WIDTH-1:0] AddressBus,
  input  logic [DATA_WIDTH-1:0] DataMemoryInput,
`ifdef DMEM_STATS_EN
  output logic [31:0]           read_count,
  output logic [31:0]           write_count,
`endif
  output logic [DATA_WIDTH-1:0] DataMemoryOutput
);

  localparam int IW = $clog2(DEPTH);

  logic [IW-1:0]         wordIdx;
  logic [DATA_WIDTH-1:0] rdWord;
  logic                  wrAccept;
  logic                  rdActive;

  if (DEPTH == DMEM_DEPTH && ADDR_WIDTH == DMEM_ADDR_WIDTH) begin : gPkgIdx
    assign wordIdx = addr_to_index(AddressBus);
  end else begin : gSliceIdx
    assign wordIdx = IW'(AddressBus >> 2);
  end

  // Reset wins over a same-cycle write.
  assign wrAccept = MemWriteEn & ~rst;
  assign rdActive = MemReadEn & ~rst;

  dmem_word_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IW        (IW)
  ) uArray (
    .clock (clock),
    .clear (rst),
    .wrEn  (wrAccept),
    .wrIdx (wordIdx),
    .wrData(DataMemoryInput),
    .rdIdx (wordIdx),
    .rdData(rdWord)
  );

  assign DataMemoryOutput = rdActive ? rdWord : '0;

`ifdef DMEM_STATS_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (MemReadEn && read_count != '1) begin
        read_count <= read_count + 32'd1;
      end
      if (MemWriteEn && write_count != '1) begin
        write_count <= write_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Randomised + directed bench for data_memory against a word-array model.
module tb_data_memory;

  logic        clock;
  logic        rst;
  logic        MemReadEn;
  logic        MemWriteEn;
  logic [31:0] AddressBus;
  logic [31:0] DataMemoryInput;
  logic [31:0] DataMemoryOutput;
`ifdef DMEM_STATS_EN
  logic [31:0] read_count;
  logic [31:0] write_count;
`endif

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  logic [31:0] model [1024];
  longint mReads = 0;
  longint mWrites = 0;

  data_memory dut (
    .clock           (clock),
    .rst             (rst),
    .MemReadEn       (MemReadEn),
    .MemWriteEn      (MemWriteEn),
    .AddressBus      (AddressBus),
    .DataMemoryInput (DataMemoryInput),
`ifdef DMEM_STATS_EN
    .read_count      (read_count),
    .write_count     (write_count),
`endif
    .DataMemoryOutput(DataMemoryOutput)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Reference: a plain 1024-word array indexed by byte address / 4 mod 1024.
  always @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) model[i] = 32'h0;
      mReads = 0;
      mWrites = 0;
    end else begin
      if (MemWriteEn) model[(AddressBus / 4) % 1024] = DataMemoryInput;
      if (MemReadEn) mReads = mReads + 1;
      if (MemWriteEn) mWrites = mWrites + 1;
    end
  end

  function automatic logic [31:0] expOut();
    if (rst || !MemReadEn) return 32'h0;
    return model[(AddressBus / 4) % 1024];
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    if (checkEn) begin
      chk("model_out", DataMemoryOutput, expOut());
`ifdef DMEM_STATS_EN
      chk("model_rdcnt", read_count, mReads > 64'hFFFF_FFFF ?
          32'hFFFF_FFFF : mReads[31:0]);
      chk("model_wrcnt", write_count, mWrites > 64'hFFFF_FFFF ?
          32'hFFFF_FFFF : mWrites[31:0]);
`endif
    end
  end

  task automatic drive(input logic r, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    rst = r;
    MemReadEn = rd;
    MemWriteEn = wr;
    AddressBus = a;
    DataMemoryInput = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0);
    tick();
    tick();
    checkEn = 1;

    drive(0, 1, 0, 32'h0, 0);
    chk("rst_rd0", DataMemoryOutput, 32'h0);
    tick();
    drive(0, 1, 0, 32'h4, 0);
    chk("rst_rd4", DataMemoryOutput, 32'h0);
    tick();
    drive(0, 1, 0, 32'hFFC, 0);
    chk("rst_rdffc", DataMemoryOutput, 32'h0);
    tick();

    drive(0, 0, 1, 32'h10, 32'hDEADBEEF);
    tick();
    drive(0, 1, 0, 32'h10, 0);
    chk("rd_10", DataMemoryOutput, 32'hDEADBEEF);
    drive(0, 1, 0, 32'h11, 0);
    chk("rd_11", DataMemoryOutput, 32'hDEADBEEF);
    drive(0, 1, 0, 32'h13, 0);
    chk("rd_13", DataMemoryOutput, 32'hDEADBEEF);
    drive(0, 1, 0, 32'h14, 0);
    chk("rd_14", DataMemoryOutput, 32'h0);
    tick();

    drive(0, 0, 1, 32'h0, 32'h12345678);
    tick();
    drive(0, 0, 1, 32'h1000, 32'hCAFEF00D);
    tick();
    drive(0, 1, 0, 32'h0, 0);
    chk("wrap", DataMemoryOutput, 32'hCAFEF00D);
    tick();

    drive(0, 0, 1, 32'h20, 32'h11111111);
    tick();
    drive(0, 1, 1, 32'h20, 32'h22222222);
    chk("rw_before", DataMemoryOutput, 32'h11111111);
    tick();
    chk("rw_after", DataMemoryOutput, 32'h22222222);
    drive(0, 0, 0, 32'h20, 0);
    chk("rd_off", DataMemoryOutput, 32'h0);
    tick();

    drive(1, 1, 1, 32'h8, 32'h55);
    chk("rst_out", DataMemoryOutput, 32'h0);
    tick();
    drive(0, 1, 0, 32'h8, 0);
    chk("rst_drop", DataMemoryOutput, 32'h0);
    drive(0, 1, 0, 32'h10, 0);
    chk("rst_clear", DataMemoryOutput, 32'h0);
    tick();

`ifdef DMEM_STATS_EN
    drive(1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'(i * 4), 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 32'(i * 4), 32'hA5A5_0000 + 32'(i));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("stat_rd3", read_count, 32'd3);
    chk("stat_wr2", write_count, 32'd2);
    drive(1, 0, 0, 0, 0);
    tick();
    chk("stat_rd0", read_count, 32'd0);
    chk("stat_wr0", write_count, 32'd0);
`endif

    // Random traffic over 16 words with random high bits to exercise wrap.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_F03F,
            $urandom);
      tick();
    end

    checkEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
